add16_bist: RTL and testbench
=============================

ADD16_BIST -- requirements
Module: add16_bist

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 16: width of the DUT operands and result.
REQ-002 The block SHALL have parameter DUT_LATENCY, default 5: clock cycles from an operand pair on dut_a/dut_b to its result on dut_sum.
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic rises on posedge clk.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle pulse that begins a test run.
REQ-006 The block SHALL have port abort, input, 1: terminates a run in progress.
REQ-007 The block SHALL have port num_vectors, input, 16: number of operand pairs to issue, sampled on start.
REQ-008 The block SHALL have ports seed_a and seed_b, input, 16 each: LFSR seeds, sampled on start.
REQ-009 The block SHALL have ports dut_a and dut_b, output, BITWIDTH each: registered operands to the DUT.
REQ-010 The block SHALL have port dut_sum, input, BITWIDTH: DUT result.
REQ-011 The block SHALL have ports busy, done and pass, output, 1 each: status.
REQ-012 The block SHALL have ports err_count and first_err_idx, output, 16 each: mismatch count, and index of the first mismatching vector.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; start SHALL be honoured only in IDLE or DONE and ignored otherwise.
REQ-014 On start, the block SHALL load the LFSRs (a zero seed is replaced by 16'hACE1), clear err_count/first_err_idx/done and set pass=1; it SHALL then go to RUN, or to DONE if num_vectors==0.
REQ-015 The LFSR SHALL be Fibonacci type, polynomial x^16+x^14+x^13+x^11+1, stepped once per issued vector; vector 0 SHALL equal the seed.
REQ-016 In RUN, the block SHALL issue one vector per cycle on dut_a/dut_b (vector k in the k-th RUN cycle) and go to DRAIN after num_vectors are issued; outside RUN, dut_a/dut_b SHALL hold 0.
REQ-017 The expected result SHALL be (f(a)+f(b)) mod 2^BITWIDTH, where f(x) = low half of x*x XOR high half of x*x (2*BITWIDTH-bit product).
REQ-018 Expected values SHALL enter a DUT_LATENCY-deep valid/expected/index delay line aligned so that vector k is compared with dut_sum exactly DUT_LATENCY cycles after it appears on dut_a.
REQ-019 On each valid mismatch, the block SHALL increment err_count (saturating at 16'hFFFF), clear pass, and capture the index in first_err_idx on the first mismatch only.
REQ-020 DRAIN SHALL go to DONE on the cycle the delay line holds no valid entries.
REQ-021 In DONE, done SHALL be 1 and results SHALL hold until the next start.
REQ-022 busy SHALL be 1 in RUN and DRAIN.
REQ-023 In RUN or DRAIN, abort SHALL flush the delay line and return to IDLE with done=0; results are then undefined-but-stable.
REQ-024 If abort and start are asserted in the same cycle, abort SHALL win.

Reset
REQ-025 rst SHALL set: state IDLE, delay line invalid, dut_a=dut_b=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, LFSRs=16'hACE1.
REQ-026 Reset asserted mid-run SHALL discard the run with no partial result reported.

Structure
REQ-027 The package add16_bist_pkg SHALL hold the FSM state enum, the LFSR polynomial taps, the zero-seed substitute constant and the f() fold function.
REQ-028 The LFSR SHALL be the single sub-module lfsr16 (load, step, seed, value), instantiated twice.

Verification
REQ-029 Bench scenario 1: seed_a=16'h0001, seed_b=16'hFFFF, num_vectors=1, golden DUT at latency 5 -> vector 0 is a=0001, b=FFFF, expected 0x0001+0xFFFF=0x0000; done 7 cycles after start with pass=1 and err_count=0.
REQ-030 Bench scenario 2: num_vectors=100, golden DUT -> busy for 100+5 cycles, done=1, pass=1, err_count=0.
REQ-031 Bench scenario 3: num_vectors=10, bench flips dut_sum bit 0 for vectors 2 and 7 only -> err_count=2, first_err_idx=2, pass=0.
REQ-032 Bench scenario 4: num_vectors=0 -> DONE the next cycle, pass=1, and dut_a is never nonzero.
REQ-033 Bench scenario 5: abort in the 3rd RUN cycle, and separately rst in DRAIN -> IDLE, done=0, and a subsequent start with the same seeds reproduces an identical vector stream.
REQ-034 Bench scenario 6: seed_a=0 -> first dut_a=16'hACE1; start while busy -> ignored, with num_vectors unchanged.

Source files
------------

// File: rtl/add16_bist_pkg.sv
// Shared types, LFSR constants and the operand fold used for adder self-test.
// Covers operand widths up to 32 bits.
package add16_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;
  localparam logic [15:0] SEED_ZERO_SUB = 16'hACE1;

  function automatic logic [15:0] seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? SEED_ZERO_SUB : seed;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {^(x & LFSR_TAPS), x[15:1]};
  endfunction

  // Low half of x*x XOR high half of x*x, for a w-bit operand.
  function automatic logic [31:0] fold(input logic [31:0] x, input int unsigned w);
    logic [63:0] prod;
    logic [63:0] mask;
    prod = {32'd0, x} * {32'd0, x};
    mask = (64'd1 << w) - 64'd1;
    return 32'((prod & mask) ^ ((prod >> w) & mask));
  endfunction

endpackage

// File: rtl/add16_bist_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load (zero seed substituted) and single-step.
module lfsr16
  import add16_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed_fix(seed);
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SEED_ZERO_SUB;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/add16_bist.sv
// BIST driver for a pipelined adder: issues LFSR operand pairs, checks the
// returned sums against a delayed expected value and reports errors.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands held at 0
// ST_RUN   | issuing one operand pair per cycle
// ST_DRAIN | all pairs issued, waiting for the last results to return
// ST_DONE  | results valid and held until the next start
module add16_bist
  import add16_bist_pkg::*;
#(
  parameter int BITWIDTH    = 16,
  parameter int DUT_LATENCY = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         num_vectors,
  input  logic [15:0]         seed_a,
  input  logic [15:0]         seed_b,
  output logic [BITWIDTH-1:0] dut_a,
  output logic [BITWIDTH-1:0] dut_b,
  input  logic [BITWIDTH-1:0] dut_sum,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         first_err_idx
);

  state_e state_q, state_d;
  logic [15:0] num_q, num_d;
  logic [15:0] idx_q, idx_d;
  logic [BITWIDTH-1:0] dut_a_q, dut_a_d;
  logic [BITWIDTH-1:0] dut_b_q, dut_b_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [15:0] first_q, first_d;

  logic [DUT_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [BITWIDTH-1:0]    dl_exp_q [DUT_LATENCY];
  logic [BITWIDTH-1:0]    dl_exp_d [DUT_LATENCY];
  logic [15:0]            dl_idx_q [DUT_LATENCY];
  logic [15:0]            dl_idx_d [DUT_LATENCY];

  logic lfsr_load, lfsr_step;
  logic [15:0] lfsr_a, lfsr_b;
  logic [BITWIDTH-1:0] exp_in;
  logic kill, start_ok, mismatch;

  lfsr16 u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_a),
    .value (lfsr_a)
  );

  lfsr16 u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_b),
    .value (lfsr_b)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    dut_a_d   = '0;
    dut_b_d   = '0;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    dl_vld_d  = dl_vld_q;
    dl_exp_d  = dl_exp_q;
    dl_idx_d  = dl_idx_q;

    kill     = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
    start_ok = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    exp_in   = BITWIDTH'(fold(32'(dut_a_q), BITWIDTH) + fold(32'(dut_b_q), BITWIDTH));

    // Entry 0 is loaded with the pair currently on dut_a/dut_b, so the last
    // entry lines up with dut_sum exactly DUT_LATENCY cycles later.
    dl_vld_d[0] = (state_q == ST_RUN);
    dl_exp_d[0] = exp_in;
    dl_idx_d[0] = idx_q;
    for (int i = 1; i < DUT_LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_exp_d[i] = dl_exp_q[i-1];
      dl_idx_d[i] = dl_idx_q[i-1];
    end

    mismatch = dl_vld_q[DUT_LATENCY-1] && (dl_exp_q[DUT_LATENCY-1] != dut_sum);
    if (mismatch && !kill) begin
      err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      pass_d = 1'b0;
      if (err_q == 16'd0) begin
        first_d = dl_idx_q[DUT_LATENCY-1];
      end
    end

    if (kill) begin
      dl_vld_d = '0;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          num_d     = num_vectors;
          idx_d     = 16'd0;
          lfsr_load = 1'b1;
          err_d     = 16'd0;
          first_d   = 16'd0;
          pass_d    = 1'b1;
          if (num_vectors == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            dut_a_d = BITWIDTH'(seed_fix(seed_a));
            dut_b_d = BITWIDTH'(seed_fix(seed_b));
          end
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          idx_d     = idx_q + 16'd1;
          if (idx_q == num_q - 16'd1) begin
            state_d = ST_DRAIN;
          end else begin
            dut_a_d = BITWIDTH'(lfsr_next(lfsr_a));
            dut_b_d = BITWIDTH'(lfsr_next(lfsr_b));
          end
        end
      end
      ST_DRAIN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (dl_vld_d == '0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      num_q    <= 16'd0;
      idx_q    <= 16'd0;
      dut_a_q  <= '0;
      dut_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'd0;
      first_q  <= 16'd0;
      dl_vld_q <= '0;
      for (int i = 0; i < DUT_LATENCY; i++) begin
        dl_exp_q[i] <= '0;
        dl_idx_q[i] <= 16'd0;
      end
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      dut_a_q  <= dut_a_d;
      dut_b_q  <= dut_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
      dl_vld_q <= dl_vld_d;
      dl_exp_q <= dl_exp_d;
      dl_idx_q <= dl_idx_d;
    end
  end

  assign dut_a         = dut_a_q;
  assign dut_b         = dut_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_add16_bist.sv
// Scenario bench for add16_bist with a 5-cycle golden adder and a vector scoreboard.
module tb_add16_bist;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_vectors;
  logic [15:0] seed_a;
  logic [15:0] seed_b;
  logic [15:0] dut_a;
  logic [15:0] dut_b;
  logic [15:0] dut_sum;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;

  int n_cmp;
  int n_bad;

  logic [31:0] exp_q [$];
  logic [31:0] e;

  logic        corrupt_en;
  logic [15:0] c2a, c2b, c7a, c7b;
  logic        corrupt;
  logic [15:0] gp [5];

  add16_bist #(.BITWIDTH(16), .DUT_LATENCY(5)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .num_vectors   (num_vectors),
    .seed_a        (seed_a),
    .seed_b        (seed_b),
    .dut_a         (dut_a),
    .dut_b         (dut_b),
    .dut_sum       (dut_sum),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_next(input logic [15:0] x);
    logic fb;
    fb = x[0] ^ x[2] ^ x[3] ^ x[5];
    return {fb, x[15:1]};
  endfunction

  function automatic logic [15:0] m_fold(input logic [15:0] x);
    logic [31:0] p;
    p = 32'(x) * 32'(x);
    return p[15:0] ^ p[31:16];
  endfunction

  // Golden adder: 5 register stages, optional bit-0 corruption of chosen pairs.
  always_comb begin
    corrupt = corrupt_en && (((dut_a == c2a) && (dut_b == c2b)) ||
                             ((dut_a == c7a) && (dut_b == c7b)));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) gp[i] <= 16'd0;
    end else begin
      gp[0] <= (m_fold(dut_a) + m_fold(dut_b)) ^ {15'd0, corrupt};
      for (int i = 1; i < 5; i++) gp[i] <= gp[i-1];
    end
  end
  assign dut_sum = gp[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Push the expected vector stream, then pulse start; returns at first RUN cycle + #1.
  task automatic start_run(input logic [15:0] sa, input logic [15:0] sb, input int n);
    logic [15:0] a, b;
    a = (sa == 16'd0) ? 16'hACE1 : sa;
    b = (sb == 16'd0) ? 16'hACE1 : sb;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({a, b});
      a = m_next(a);
      b = m_next(b);
    end
    @(negedge clk);
    seed_a      = sa;
    seed_b      = sb;
    num_vectors = 16'(n);
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max, inout int cyc, inout int bcyc, output bit to);
    to = 1'b0;
    while (done !== 1'b1) begin
      if (cyc >= max) begin
        to = 1'b1;
        break;
      end
      if (busy === 1'b1) bcyc++;
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({dut_a, dut_b, busy, done, pass, err_count, first_err_idx} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got a=%h b=%h busy=%b done=%b pass=%b err=%h first=%h want all zero",
               dut_a, dut_b, busy, done, pass, err_count, first_err_idx);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_single;
    int cyc, bcyc;
    bit to;
    cyc = 0;
    bcyc = 0;
    start_run(16'h0001, 16'hFFFF, 1);
    n_cmp++;
    if (dut_a !== 16'h0001 || dut_b !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL single_vec0: got a=%h b=%h want a=0001 b=ffff", dut_a, dut_b);
    end
    e = exp_q.pop_front();
    if (busy === 1'b1) bcyc++;
    @(posedge clk);
    #1 cyc++;
    wait_done(50, cyc, bcyc, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL single_timeout: done not seen after %0d cycles", cyc);
    end
    // start raised one cycle before its sampling edge: done on the 7th posedge after that
    n_cmp++;
    if (cyc + 1 !== 7) begin
      n_bad++;
      $display("FAIL single_done_latency: got %0d want 7", cyc + 1);
    end
    n_cmp++;
    if (bcyc !== 6) begin
      n_bad++;
      $display("FAIL single_busy_cycles: got %0d want 6", bcyc);
    end
    n_cmp++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL single_result: got pass=%b err=%0d want pass=1 err=0", pass, err_count);
    end
  endtask

  task automatic test_long;
    int cyc, bcyc;
    bit to;
    cyc = 0;
    bcyc = 0;
    start_run(16'hBEEF, 16'h1234, 100);
    for (int k = 0; k < 100; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL long_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      if (busy === 1'b1) bcyc++;
      @(posedge clk);
      #1 cyc++;
    end
    wait_done(300, cyc, bcyc, to);
    n_cmp++;
    if (to || bcyc !== 105) begin
      n_bad++;
      $display("FAIL long_busy_cycles: got %0d (timeout=%0d) want 105", bcyc, to);
    end
    n_cmp++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL long_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
    end
    n_cmp++;
    if (dut_a !== 16'd0) begin
      n_bad++;
      $display("FAIL long_idle_operand: got a=%h want 0000", dut_a);
    end
  endtask

  task automatic test_errors;
    int cyc, bcyc;
    bit to;
    logic [15:0] a, b;
    cyc = 0;
    bcyc = 0;
    a = 16'h1357;
    b = 16'h2468;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin c2a = a; c2b = b; end
      if (k == 7) begin c7a = a; c7b = b; end
      a = m_next(a);
      b = m_next(b);
    end
    corrupt_en = 1'b1;
    start_run(16'h1357, 16'h2468, 10);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL err_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      @(posedge clk);
      #1 cyc++;
    end
    wait_done(100, cyc, bcyc, to);
    corrupt_en = 1'b0;
    n_cmp++;
    if (to || err_count !== 16'd2) begin
      n_bad++;
      $display("FAIL err_count: got %0d (timeout=%0d) want 2", err_count, to);
    end
    n_cmp++;
    if (first_err_idx !== 16'd2) begin
      n_bad++;
      $display("FAIL err_first_idx: got %0d want 2", first_err_idx);
    end
    n_cmp++;
    if (pass !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pass: got %b want 0", pass);
    end
  endtask

  task automatic test_zero;
    bit nz;
    start_run(16'h5555, 16'hAAAA, 0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done_next: got done=%b busy=%b want 1 0", done, busy);
    end
    n_cmp++;
    if (pass !== 1'b1 || err_count !== 16'd0 || first_err_idx !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_result: got pass=%b err=%0d first=%0d want 1 0 0", pass, err_count, first_err_idx);
    end
    nz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (dut_a !== 16'd0) nz = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (nz !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_operand: got nonzero dut_a=%b want never", nz);
    end
  endtask

  task automatic test_abort_reset;
    int cyc, bcyc;
    bit to;
    start_run(16'h4321, 16'h8765, 20);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL abort_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      if (k == 2) abort = 1'b1;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_a !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_idle: got busy=%b done=%b a=%h want 0 0 0000", busy, done, dut_a);
    end
    cyc = 0;
    bcyc = 0;
    start_run(16'h4321, 16'h8765, 20);
    for (int k = 0; k < 20; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL abort_rerun_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      @(posedge clk);
      #1 cyc++;
    end
    wait_done(100, cyc, bcyc, to);
    n_cmp++;
    if (to || pass !== 1'b1 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL abort_rerun_result: got timeout=%0d pass=%b err=%0d want 0 1 0", to, pass, err_count);
    end

    start_run(16'h0F0F, 16'hF00F, 4);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL rst_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (busy !== 1'b1 || dut_a !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_in_drain: got busy=%b a=%h want 1 0000", busy, dut_a);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_midrun: got busy=%b done=%b pass=%b err=%0d want 0 0 0 0", busy, done, pass, err_count);
    end
    @(negedge clk) rst = 1'b0;
    cyc = 0;
    bcyc = 0;
    start_run(16'h0F0F, 16'hF00F, 4);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL rst_rerun_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      @(posedge clk);
      #1 cyc++;
    end
    wait_done(50, cyc, bcyc, to);
    n_cmp++;
    if (to || done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_rerun_result: got timeout=%0d done=%b pass=%b err=%0d want 0 1 1 0", to, done, pass, err_count);
    end
  endtask

  task automatic test_seed_busy;
    int cyc, bcyc;
    bit to;
    cyc = 0;
    bcyc = 0;
    start_run(16'h0000, 16'h1234, 5);
    n_cmp++;
    if (dut_a !== 16'hACE1) begin
      n_bad++;
      $display("FAIL zero_seed_sub: got a=%h want ace1", dut_a);
    end
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({dut_a, dut_b} !== e) begin
        n_bad++;
        $display("FAIL busy_start_vec%0d: got a=%h b=%h want a=%h b=%h", k, dut_a, dut_b, e[31:16], e[15:0]);
      end
      if (busy === 1'b1) bcyc++;
      if (k == 0) begin
        @(negedge clk);
        seed_a      = 16'h0007;
        seed_b      = 16'h0009;
        num_vectors = 16'd50;
        start       = 1'b1;
      end
      @(posedge clk);
      #1 cyc++;
      start = 1'b0;
    end
    wait_done(100, cyc, bcyc, to);
    n_cmp++;
    if (to || bcyc !== 10) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got busy cycles %0d (timeout=%0d) want 10", bcyc, to);
    end
    n_cmp++;
    if (pass !== 1'b1 || err_count !== 16'd0 || dut_a !== 16'd0) begin
      n_bad++;
      $display("FAIL busy_start_result: got pass=%b err=%0d a=%h want 1 0 0000", pass, err_count, dut_a);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    num_vectors = 16'd0;
    seed_a      = 16'd0;
    seed_b      = 16'd0;
    corrupt_en  = 1'b0;
    c2a = 16'd0; c2b = 16'd0; c7a = 16'd0; c7b = 16'd0;

    test_reset();
    test_single();
    test_long();
    test_errors();
    test_zero();
    test_abort_reset();
    test_seed_busy();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
